button_mode_ctrl: RTL and testbench

Front-panel controller that turns the nine debounced button levels into mode, field and edit commands for the clock/date/chronometer registers. It sits directly downstream of the button debouncer and arbitrates the shared button bank between hour, date and chrono programming. It produces edge-detected, auto-repeating, single-cycle command pulses for the timekeeping datapath.

---
 rtl/panel_pkg.sv | 44 ++++
 rtl/btn_autorepeat.sv | 59 +++++
 rtl/button_mode_ctrl.sv | 161 ++++++++++++++++
 tb/tb_button_mode_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/panel_pkg.sv
// -----------------------------------------------------------------------------
// panel_pkg
// Shared definitions for the front-panel button controller: mode encodings,
// button bundle layout, default timing constants and field-step helpers.
// -----------------------------------------------------------------------------
package panel_pkg;

   // Programming mode, also driven directly onto the 2-bit mode output.
   typedef enum logic [1:0] {
      MODE_IDLE   = 2'b00,
      MODE_HOUR   = 2'b01,
      MODE_DATE   = 2'b10,
      MODE_CHRONO = 2'b11
   } mode_t;

   // The nine debounced buttons, kept together so edge detection is one vector op.
   typedef struct packed {
      logic up;
      logic down;
      logic left;
      logic right;
      logic fmt;
      logic ph;
      logic pf;
      logic pc;
      logic ic;
   } btn_t;

   localparam int NUM_FIELDS = 3;

   localparam int DEF_REPEAT_START = 25_000_000;
   localparam int DEF_REPEAT_RATE  = 5_000_000;
   localparam int DEF_TIMEOUT      = 500_000_000;

   // Field selection moves around a ring of NUM_FIELDS entries.
   function automatic logic [1:0] field_next(input logic [1:0] f);
      return (f == 2'(NUM_FIELDS - 1)) ? 2'd0 : f + 2'd1;
   endfunction

   function automatic logic [1:0] field_prev(input logic [1:0] f);
      return (f == 2'd0) ? 2'(NUM_FIELDS - 1) : f - 2'd1;
   endfunction

endpackage

// File: rtl/btn_autorepeat.sv
// -----------------------------------------------------------------------------
// btn_autorepeat
// Turns one held edit button into a pulse on its rising edge, then a pulse
// after REPEAT_START held cycles and every REPEAT_RATE cycles after that.
// Ports:
//   clk, reset   : system clock, synchronous active-high reset
//   level        : debounced button level
//   rise         : rising edge of level (from the owner's edge registers)
//   enable       : editing allowed this cycle; counter held at 0 otherwise
//   other_held   : the opposing edit button is down; suppresses everything
//   pulse        : combinational fire strobe, registered by the owner
// -----------------------------------------------------------------------------
module btn_autorepeat
   import panel_pkg::*;
#(
   parameter int REPEAT_START = DEF_REPEAT_START,
   parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
   input  logic clk,
   input  logic reset,
   input  logic level,
   input  logic rise,
   input  logic enable,
   input  logic other_held,
   output logic pulse
);

   localparam int CW = $clog2(REPEAT_START + 1);
   localparam logic [CW-1:0] START_C  = CW'(REPEAT_START);
   localparam logic [CW-1:0] RELOAD_C = CW'(REPEAT_START - REPEAT_RATE);

   logic [CW-1:0] hold_cnt, hold_cnt_nxt;

   // The counter tracks held cycles after the edge cycle, so the first repeat
   // lands REPEAT_START cycles after the edge pulse. Reloading below START
   // keeps it from ever passing START, which also makes it saturating.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no latch is inferred.
      hold_cnt_nxt = '0;
      pulse        = 1'b0;
      if (enable && level && !other_held) begin
         if (rise) begin
            pulse = 1'b1;
         end else if (hold_cnt >= START_C - 1'b1) begin
            pulse        = 1'b1;
            hold_cnt_nxt = RELOAD_C;
         end else begin
            hold_cnt_nxt = hold_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (reset) hold_cnt <= '0;
      else       hold_cnt <= hold_cnt_nxt;
   end

endmodule

// File: rtl/button_mode_ctrl.sv
// -----------------------------------------------------------------------------
// button_mode_ctrl
// Front-panel controller: arbitrates the shared button bank between hour,
// date and chrono programming and emits registered single-cycle commands.
// Ports:
//   clk, reset                     : system clock, synchronous active-high reset
//   btn_up/down/left/right         : debounced edit buttons
//   btn_fmt, btn_ic                : format toggle, chrono start/stop
//   btn_ph, btn_pf, btn_pc         : program hour / date / chrono
//   mode [1:0], field [1:0]        : current programming mode and field
//   inc, dec                       : edit pulses (with auto-repeat)
//   commit, abort                  : end-of-programming pulses
//   fmt_toggle, chrono_toggle      : IDLE-only command pulses
// -----------------------------------------------------------------------------
module button_mode_ctrl
   import panel_pkg::*;
#(
   parameter int REPEAT_START = DEF_REPEAT_START,
   parameter int REPEAT_RATE  = DEF_REPEAT_RATE,
   parameter int TIMEOUT      = DEF_TIMEOUT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_fmt,
   input  logic       btn_ph,
   input  logic       btn_pf,
   input  logic       btn_pc,
   input  logic       btn_ic,
   output logic [1:0] mode,
   output logic [1:0] field,
   output logic       inc,
   output logic       dec,
   output logic       commit,
   output logic       abort,
   output logic       fmt_toggle,
   output logic       chrono_toggle
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

   btn_t          btn_now, btn_prev, rise;
   mode_t         mode_q, mode_d;
   logic [1:0]    field_q, field_d;
   logic [TW-1:0] tcnt_q, tcnt_d;
   logic          commit_d, abort_d, fmt_d, chrono_d;
   logic          in_prog, own_rise, timeout_hit, leave, edit_en;
   logic          up_fire, dn_fire;

   assign btn_now = {btn_up, btn_down, btn_left, btn_right, btn_fmt,
                     btn_ph, btn_pf, btn_pc, btn_ic};
   assign rise    = btn_now & ~btn_prev;

   assign mode  = mode_q;
   assign field = field_q;

   // Exit conditions are resolved ahead of the main next-state logic so the
   // repeat units can be disabled on the exit cycle without a feedback path.
   always_comb begin
      own_rise = 1'b0;
      case (mode_q)
         MODE_HOUR:   own_rise = rise.ph;
         MODE_DATE:   own_rise = rise.pf;
         MODE_CHRONO: own_rise = rise.pc;
         default:     own_rise = 1'b0;
      endcase
   end

   assign in_prog     = (mode_q != MODE_IDLE);
   assign timeout_hit = in_prog && (tcnt_q == TO_LAST);
   assign leave       = in_prog && (own_rise || timeout_hit);
   assign edit_en     = in_prog && !leave;

   // Each unit is vetoed by the other button's level, so inc and dec are exclusive.
   btn_autorepeat #(
      .REPEAT_START (REPEAT_START),
      .REPEAT_RATE  (REPEAT_RATE)
   ) u_rep_up (
      .clk        (clk),
      .reset      (reset),
      .level      (btn_up),
      .rise       (rise.up),
      .enable     (edit_en),
      .other_held (btn_down),
      .pulse      (up_fire)
   );

   btn_autorepeat #(
      .REPEAT_START (REPEAT_START),
      .REPEAT_RATE  (REPEAT_RATE)
   ) u_rep_dn (
      .clk        (clk),
      .reset      (reset),
      .level      (btn_down),
      .rise       (rise.down),
      .enable     (edit_en),
      .other_held (btn_up),
      .pulse      (dn_fire)
   );

   always_comb begin
      mode_d   = mode_q;
      field_d  = field_q;
      tcnt_d   = '0;
      commit_d = 1'b0;
      abort_d  = 1'b0;
      fmt_d    = 1'b0;
      chrono_d = 1'b0;
      if (!in_prog) begin
         field_d  = '0;
         fmt_d    = rise.fmt;
         chrono_d = rise.ic;
         if      (rise.ph) mode_d = MODE_HOUR;
         else if (rise.pf) mode_d = MODE_DATE;
         else if (rise.pc) mode_d = MODE_CHRONO;
      end else if (leave) begin
         // A matching mode-button edge outranks a timeout in the same cycle.
         mode_d   = MODE_IDLE;
         field_d  = '0;
         commit_d = own_rise;
         abort_d  = !own_rise;
      end else begin
         if (rise.right && !rise.left)      field_d = field_next(field_q);
         else if (rise.left && !rise.right) field_d = field_prev(field_q);
         if (|rise || up_fire || dn_fire) tcnt_d = '0;
         else if (tcnt_q != '1)           tcnt_d = tcnt_q + 1'b1;
         else                             tcnt_d = tcnt_q;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: the previous-level registers load live inputs even under reset, so a button held through reset release yields no edge.
      btn_prev <= btn_now;
      if (reset) begin
         mode_q        <= MODE_IDLE;
         field_q       <= '0;
         tcnt_q        <= '0;
         inc           <= 1'b0;
         dec           <= 1'b0;
         commit        <= 1'b0;
         abort         <= 1'b0;
         fmt_toggle    <= 1'b0;
         chrono_toggle <= 1'b0;
      end else begin
         mode_q        <= mode_d;
         field_q       <= field_d;
         tcnt_q        <= tcnt_d;
         inc           <= up_fire;
         dec           <= dn_fire;
         commit        <= commit_d;
         abort         <= abort_d;
         fmt_toggle    <= fmt_d;
         chrono_toggle <= chrono_d;
      end
   end

endmodule

// File: tb/tb_button_mode_ctrl.sv
// -----------------------------------------------------------------------------
// tb_button_mode_ctrl
// Self-checking bench for button_mode_ctrl with REPEAT_START=10,
// REPEAT_RATE=4, TIMEOUT=50. Expected outputs are queued as each stimulus
// cycle is driven and popped for comparison one edge later.
// -----------------------------------------------------------------------------
module tb_button_mode_ctrl;

   // {mode, field, inc, dec, commit, abort, fmt_toggle, chrono_toggle}
   typedef struct packed {
      logic [1:0] mode;
      logic [1:0] field;
      logic [5:0] pulses;
   } out_t;

   typedef struct {
      logic [8:0] btn;
      out_t       exp;
      string      name;
   } vec_t;

   // Button bit order: up, down, left, right, fmt, ph, pf, pc, ic.
   localparam logic [8:0] B_NONE  = 9'h000;
   localparam logic [8:0] B_UP    = 9'h100;
   localparam logic [8:0] B_DOWN  = 9'h080;
   localparam logic [8:0] B_LEFT  = 9'h040;
   localparam logic [8:0] B_RIGHT = 9'h020;
   localparam logic [8:0] B_FMT   = 9'h010;
   localparam logic [8:0] B_PH    = 9'h008;
   localparam logic [8:0] B_PF    = 9'h004;
   localparam logic [8:0] B_PC    = 9'h002;
   localparam logic [8:0] B_IC    = 9'h001;

   // Pulse order: inc, dec, commit, abort, fmt_toggle, chrono_toggle.
   localparam logic [5:0] P_NONE = 6'b000000;
   localparam logic [5:0] P_INC  = 6'b100000;
   localparam logic [5:0] P_DEC  = 6'b010000;
   localparam logic [5:0] P_COM  = 6'b001000;
   localparam logic [5:0] P_ABT  = 6'b000100;
   localparam logic [5:0] P_FMT  = 6'b000010;
   localparam logic [5:0] P_CHR  = 6'b000001;

   logic       clk;
   logic       reset;
   logic       btn_up, btn_down, btn_left, btn_right, btn_fmt;
   logic       btn_ph, btn_pf, btn_pc, btn_ic;
   logic [1:0] mode, field;
   logic       inc, dec, commit, abort, fmt_toggle, chrono_toggle;

   int    n_cmp  = 0;
   int    n_fail = 0;
   out_t  exp_q[$];
   string name_q[$];
   vec_t  vecs[$];

   button_mode_ctrl #(
      .REPEAT_START (10),
      .REPEAT_RATE  (4),
      .TIMEOUT      (50)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .btn_up        (btn_up),
      .btn_down      (btn_down),
      .btn_left      (btn_left),
      .btn_right     (btn_right),
      .btn_fmt       (btn_fmt),
      .btn_ph        (btn_ph),
      .btn_pf        (btn_pf),
      .btn_pc        (btn_pc),
      .btn_ic        (btn_ic),
      .mode          (mode),
      .field         (field),
      .inc           (inc),
      .dec           (dec),
      .commit        (commit),
      .abort         (abort),
      .fmt_toggle    (fmt_toggle),
      .chrono_toggle (chrono_toggle)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic out_t o(input int m, input int f, input logic [5:0] p);
      out_t r;
      r.mode   = 2'(m);
      r.field  = 2'(f);
      r.pulses = p;
      return r;
   endfunction

   // Drive one cycle of buttons, queue its expectation, then compare the
   // registered outputs 1 time unit after the edge that sampled the buttons.
   task automatic cycle(input logic [8:0] b, input out_t e, input string nm);
      out_t  want;
      out_t  act;
      string wn;
      {btn_up, btn_down, btn_left, btn_right, btn_fmt,
       btn_ph, btn_pf, btn_pc, btn_ic} = b;
      exp_q.push_back(e);
      name_q.push_back(nm);
      @(posedge clk);
      #1;
      want = exp_q.pop_front();
      wn   = name_q.pop_front();
      act  = {mode, field, inc, dec, commit, abort, fmt_toggle, chrono_toggle};
      n_cmp++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got mode=%0d field=%0d pulses=%b, want mode=%0d field=%0d pulses=%b (inc,dec,commit,abort,fmt,chrono)",
                  wn, act.mode, act.field, act.pulses, want.mode, want.field, want.pulses);
      end
   endtask

   task automatic add(input logic [8:0] b, input out_t e, input string nm);
      vec_t v;
      v.btn  = b;
      v.exp  = e;
      v.name = nm;
      vecs.push_back(v);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1;
      {btn_up, btn_down, btn_left, btn_right, btn_fmt,
       btn_ph, btn_pf, btn_pc, btn_ic} = '0;

      // 1. ph held through reset release: no edge, then a fresh press enters PROG_HOUR.
      cycle(B_PH,   o(0, 0, P_NONE), "reset_state");
      reset = 1'b0;
      cycle(B_PH,   o(0, 0, P_NONE), "ph_held_over_reset");
      cycle(B_PH,   o(0, 0, P_NONE), "ph_still_held");
      cycle(B_NONE, o(0, 0, P_NONE), "ph_released");
      cycle(B_PH,   o(1, 0, P_NONE), "ph_enter_hour");
      cycle(B_NONE, o(1, 0, P_NONE), "hour_idle");
      cycle(B_PH,   o(0, 0, P_COM),  "hour_commit");
      cycle(B_NONE, o(0, 0, P_NONE), "after_commit");

      // 2. Simultaneous ph and pc: ph wins, pc later ignored, ph commits.
      cycle(B_PH | B_PC, o(1, 0, P_NONE), "ph_pc_same_cycle");
      cycle(B_NONE,      o(1, 0, P_NONE), "ph_pc_release");
      cycle(B_PC,        o(1, 0, P_NONE), "pc_ignored_in_hour");
      cycle(B_NONE,      o(1, 0, P_NONE), "pc_release");
      cycle(B_PH,        o(0, 0, P_COM),  "ph_commit");
      cycle(B_NONE,      o(0, 0, P_NONE), "commit_one_cycle");

      // 3 and 6. Field wrap, edits and mode-qualified buttons, table-driven.
      add(B_PF,           o(2, 0, P_NONE), "enter_date");
      add(B_NONE,         o(2, 0, P_NONE), "date_idle");
      add(B_RIGHT,        o(2, 1, P_NONE), "right_1");
      add(B_NONE,         o(2, 1, P_NONE), "right_rel_1");
      add(B_RIGHT,        o(2, 2, P_NONE), "right_2");
      add(B_NONE,         o(2, 2, P_NONE), "right_rel_2");
      add(B_RIGHT,        o(2, 0, P_NONE), "right_wrap_0");
      add(B_NONE,         o(2, 0, P_NONE), "right_rel_3");
      add(B_LEFT,         o(2, 2, P_NONE), "left_wrap_2");
      add(B_NONE,         o(2, 2, P_NONE), "left_rel");
      add(B_LEFT|B_RIGHT, o(2, 2, P_NONE), "left_right_same");
      add(B_NONE,         o(2, 2, P_NONE), "lr_rel");
      add(B_UP,           o(2, 2, P_INC),  "up_edge_inc");
      add(B_NONE,         o(2, 2, P_NONE), "up_rel");
      add(B_DOWN,         o(2, 2, P_DEC),  "down_edge_dec");
      add(B_NONE,         o(2, 2, P_NONE), "down_rel");
      add(B_PH,           o(2, 2, P_NONE), "ph_ignored_in_date");
      add(B_NONE,         o(2, 2, P_NONE), "ph_rel");
      add(B_PF,           o(0, 0, P_COM),  "date_commit_field0");
      add(B_NONE,         o(0, 0, P_NONE), "idle_after_date");
      add(B_FMT,          o(0, 0, P_FMT),  "fmt_in_idle");
      add(B_NONE,         o(0, 0, P_NONE), "fmt_one_cycle");
      add(B_IC,           o(0, 0, P_CHR),  "ic_in_idle");
      add(B_NONE,         o(0, 0, P_NONE), "ic_one_cycle");
      add(B_UP,           o(0, 0, P_NONE), "up_in_idle");
      add(B_NONE,         o(0, 0, P_NONE), "up_idle_rel");
      add(B_RIGHT,        o(0, 0, P_NONE), "right_in_idle");
      add(B_NONE,         o(0, 0, P_NONE), "right_idle_rel");
      add(B_PH,           o(1, 0, P_NONE), "enter_hour");
      add(B_NONE,         o(1, 0, P_NONE), "hour_wait");
      add(B_FMT,          o(1, 0, P_NONE), "fmt_in_hour");
      add(B_NONE,         o(1, 0, P_NONE), "fmt_hour_rel");
      add(B_IC,           o(1, 0, P_NONE), "ic_in_hour");
      add(B_NONE,         o(1, 0, P_NONE), "ic_hour_rel");
      for (int i = 0; i < vecs.size(); i++) begin
         cycle(vecs[i].btn, vecs[i].exp, vecs[i].name);
      end

      // 4. Auto-repeat: inc on hold cycles 1, 11, 15, 19; adding down stops it.
      for (int k = 1; k <= 20; k++) begin
         cycle(B_UP, o(1, 0, (k == 1 || k == 11 || k == 15 || k == 19) ? P_INC : P_NONE),
               $sformatf("up_hold_%0d", k));
      end
      for (int k = 21; k <= 30; k++) begin
         cycle(B_UP | B_DOWN, o(1, 0, P_NONE), $sformatf("up_down_hold_%0d", k));
      end
      cycle(B_NONE, o(1, 0, P_NONE), "hold_release");
      cycle(B_PH,   o(0, 0, P_COM),  "hour_commit_after_repeat");
      cycle(B_NONE, o(0, 0, P_NONE), "idle_after_repeat");

      // 5. Timeout: abort exactly 50 cycles after entry with no input.
      cycle(B_PC, o(3, 0, P_NONE), "enter_chrono");
      for (int k = 1; k <= 49; k++) begin
         cycle(B_NONE, o(3, 0, P_NONE), $sformatf("chrono_wait_%0d", k));
      end
      cycle(B_NONE, o(0, 0, P_ABT),  "chrono_timeout_abort");
      cycle(B_NONE, o(0, 0, P_NONE), "abort_one_cycle");

      // 5b. Own mode-button edge on the timeout cycle: commit wins.
      cycle(B_PH, o(1, 0, P_NONE), "enter_hour_to");
      for (int k = 1; k <= 49; k++) begin
         cycle(B_NONE, o(1, 0, P_NONE), $sformatf("hour_wait_%0d", k));
      end
      cycle(B_PH,   o(0, 0, P_COM),  "commit_beats_timeout");
      cycle(B_NONE, o(0, 0, P_NONE), "after_commit_to");

      // Reset mid-programming: back to IDLE with no commit, held pf gives no edge.
      cycle(B_PF,   o(2, 0, P_NONE), "enter_date_rst");
      cycle(B_NONE, o(2, 0, P_NONE), "date_before_rst");
      reset = 1'b1;
      cycle(B_PF,   o(0, 0, P_NONE), "reset_mid_prog");
      reset = 1'b0;
      cycle(B_PF,   o(0, 0, P_NONE), "pf_held_after_rst");
      cycle(B_NONE, o(0, 0, P_NONE), "final_idle");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
